process_scheduler: RTL and testbench

PROCESS_SCHEDULER -- requirements
Module: process_scheduler

---
 rtl/process_scheduler_pkg.sv | 28 ++
 rtl/process_scheduler_rr_picker.sv | 32 +++
 rtl/process_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_process_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/process_scheduler_pkg.sv
// Shared definitions for the round-robin process scheduler: program count,
// program index width and the scheduler FSM state encoding.
package process_scheduler_pkg;

    // Number of program slots and the width of a slot index.
    localparam int NUM_PROGS = 16;
    localparam int PROG_W    = 4;

    // Scheduler FSM states.
    //   RUN     - a program owns the CPU, the time slice is counting
    //   SAVE    - context switcher saves the outgoing program
    //   GAP     - one idle cycle so the switcher can clear its completion flag
    //   RESTORE - context switcher restores the incoming program
    //   DONE    - one idle cycle before handing the CPU to the new program
    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SAVE    = 3'd1,
        GAP     = 3'd2,
        RESTORE = 3'd3,
        DONE    = 3'd4
    } sched_state_e;

    // The CPU is stalled in every state except RUN.
    function automatic logic stalls_cpu(input sched_state_e st);
        return (st != RUN);
    endfunction

endpackage

// File: rtl/process_scheduler_rr_picker.sv
// Combinational round-robin picker: finds the first runnable program strictly
// after the current one, wrapping from the highest slot back to slot 0. The
// current program itself is never a candidate.
module rr_picker
    import process_scheduler_pkg::*;
(
    input  logic [NUM_PROGS-1:0] mask,
    input  logic [PROG_W-1:0]    cur,
    output logic [PROG_W-1:0]    next,
    output logic                 found
);

    logic [PROG_W-1:0] idx_s;

    // Scan offsets 1..NUM_PROGS-1 from cur; the first set bit wins.
    always_comb begin
        next  = {PROG_W{1'b0}};
        found = 1'b0;
        idx_s = {PROG_W{1'b0}};
        for (int off = 1; off < NUM_PROGS; off++) begin
            idx_s = cur + off[PROG_W-1:0];
            if (!found && mask[idx_s]) begin
                found = 1'b1;
                next  = idx_s;
            end else begin
                found = found;
                next  = next;
            end
        end
    end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin time-slice scheduler. Counts down a per-program slice, and on
// expiry (or a yield) hands the CPU to the next runnable program by driving a
// save / gap / restore / done handshake with an external context switcher.
module process_scheduler
    import process_scheduler_pkg::*;
#(
    parameter int QUANTUM_W = 16
)
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [QUANTUM_W-1:0] quantum,
    input  logic [NUM_PROGS-1:0] active_mask,
    input  logic                 yield_req,
    input  logic                 cs_busy,
    output logic                 save_trigger,
    output logic                 restore_trigger,
    output logic [PROG_W-1:0]    progIndex,
    output logic [PROG_W-1:0]    current_prog,
    output logic                 cpu_stall,
    output logic                 switch_done
);

    localparam logic [QUANTUM_W-1:0] CNT_ZERO = {QUANTUM_W{1'b0}};
    localparam logic [QUANTUM_W-1:0] CNT_ONE  = QUANTUM_W'(1'b1);

    // FSM and datapath state
    sched_state_e          state_q,     state_d;
    logic [QUANTUM_W-1:0]  cnt_q,       cnt_d;
    logic [QUANTUM_W-1:0]  quant_q,     quant_d;
    logic [PROG_W-1:0]     cur_q,       cur_d;
    logic [PROG_W-1:0]     next_q,      next_d;
    logic                  seen_busy_q, seen_busy_d;

    // Registered outputs
    logic                  save_q,      save_d;
    logic                  restore_q,   restore_d;
    logic [PROG_W-1:0]     prog_idx_q,  prog_idx_d;
    logic                  stall_q,     stall_d;
    logic                  done_q,      done_d;

    // Picker results and slice bookkeeping
    logic [PROG_W-1:0]     pick_next_s;
    logic                  pick_found_s;
    logic                  slice_on_s;
    logic                  expire_s;

    rr_picker u_picker (
        .mask  (active_mask),
        .cur   (cur_q),
        .next  (pick_next_s),
        .found (pick_found_s)
    );

    // A quantum of zero turns off preemption; only a yield can end the slice.
    assign slice_on_s = (quantum != CNT_ZERO);

    // Next-state logic: slice counting in RUN and the switcher handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quant_d     = quant_q;
        cur_d       = cur_q;
        next_d      = next_q;
        seen_busy_d = seen_busy_q;
        expire_s    = 1'b0;

        case (state_q)
            RUN: begin
                // A yield while the counter is already at 1 is still one expiry.
                if (enable) begin
                    expire_s = yield_req || (slice_on_s && (cnt_q == CNT_ONE));
                end else begin
                    expire_s = 1'b0;
                end

                if (expire_s) begin
                    if (pick_found_s) begin
                        // Freeze the target and slice length for the whole switch.
                        next_d      = pick_next_s;
                        quant_d     = quantum;
                        seen_busy_d = 1'b0;
                        state_d     = SAVE;
                    end else begin
                        // Nobody else is runnable: keep running, fresh slice.
                        cnt_d = quantum;
                    end
                end else if (enable && slice_on_s) begin
                    if (cnt_q == CNT_ZERO) begin
                        // Counter was parked at 0 while preemption was off.
                        cnt_d = quantum;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            SAVE: begin
                // Wait for the switcher to go busy and then idle again.
                if (cs_busy) begin
                    seen_busy_d = 1'b1;
                end else begin
                    seen_busy_d = seen_busy_q;
                end
                if (seen_busy_q && !cs_busy) begin
                    state_d = GAP;
                end else begin
                    state_d = SAVE;
                end
            end

            GAP: begin
                seen_busy_d = 1'b0;
                state_d     = RESTORE;
            end

            RESTORE: begin
                if (cs_busy) begin
                    seen_busy_d = 1'b1;
                end else begin
                    seen_busy_d = seen_busy_q;
                end
                if (seen_busy_q && !cs_busy) begin
                    state_d = DONE;
                end else begin
                    state_d = RESTORE;
                end
            end

            DONE: begin
                cur_d       = next_q;
                cnt_d       = quant_q;
                seen_busy_d = 1'b0;
                state_d     = RUN;
            end

            default: begin
                // Unreachable encodings fall back to a safe running state.
                seen_busy_d = 1'b0;
                state_d     = RUN;
            end
        endcase
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        save_d     = (state_d == SAVE);
        restore_d  = (state_d == RESTORE);
        stall_d    = stalls_cpu(state_d);
        done_d     = (state_q == DONE);
        if (state_d == RESTORE) begin
            prog_idx_d = next_d;
        end else begin
            prog_idx_d = cur_d;
        end
    end

    // State and output registers; reset abandons any switch in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            cnt_q       <= quantum;
            quant_q     <= quantum;
            cur_q       <= {PROG_W{1'b0}};
            next_q      <= {PROG_W{1'b0}};
            seen_busy_q <= 1'b0;
            save_q      <= 1'b0;
            restore_q   <= 1'b0;
            prog_idx_q  <= {PROG_W{1'b0}};
            stall_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quant_q     <= quant_d;
            cur_q       <= cur_d;
            next_q      <= next_d;
            seen_busy_q <= seen_busy_d;
            save_q      <= save_d;
            restore_q   <= restore_d;
            prog_idx_q  <= prog_idx_d;
            stall_q     <= stall_d;
            done_q      <= done_d;
        end
    end

    assign save_trigger    = save_q;
    assign restore_trigger = restore_q;
    assign progIndex       = prog_idx_q;
    assign current_prog    = cur_q;
    assign cpu_stall       = stall_q;
    assign switch_done     = done_q;

endmodule

// File: tb/tb_process_scheduler.sv
// Self-checking bench for process_scheduler with a simple context-switcher
// model and a scoreboard of expected program hand-offs.
module tb_process_scheduler;

    localparam int BUDGET   = 300;
    localparam int BUSY_CYC = 34;

    logic        clock       = 1'b0;
    logic        reset       = 1'b1;
    logic        enable      = 1'b0;
    logic [15:0] quantum     = 16'd0;
    logic [15:0] active_mask = 16'h0000;
    logic        yield_req   = 1'b0;
    logic        cs_busy     = 1'b0;
    logic        save_trigger, restore_trigger, cpu_stall, switch_done;
    logic [3:0]  progIndex, current_prog;

    int          total    = 0;
    int          bad      = 0;
    int          timeouts = 0;
    logic        overlap_seen = 1'b0;
    logic [3:0]  exp_q[$];

    int          busy_left = 0;
    logic        served    = 1'b0;

    process_scheduler #(.QUANTUM_W(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .quantum         (quantum),
        .active_mask     (active_mask),
        .yield_req       (yield_req),
        .cs_busy         (cs_busy),
        .save_trigger    (save_trigger),
        .restore_trigger (restore_trigger),
        .progIndex       (progIndex),
        .current_prog    (current_prog),
        .cpu_stall       (cpu_stall),
        .switch_done     (switch_done)
    );

    always #5 clock = ~clock;

    // Context switcher model: busy for BUSY_CYC cycles per request, and
    // re-armed only once both triggers have dropped.
    always @(negedge clock) begin
        if (reset) begin
            cs_busy   = 1'b0;
            busy_left = 0;
            served    = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) cs_busy = 1'b0;
        end else if ((save_trigger || restore_trigger) && !served) begin
            cs_busy   = 1'b1;
            busy_left = BUSY_CYC;
            served    = 1'b1;
        end else if (!save_trigger && !restore_trigger) begin
            served = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clock);
        if (save_trigger && restore_trigger) overlap_seen = 1'b1;
    endtask

    // Wait for an event: 0 save high, 1 restore high, 2 switch_done,
    // 3 save low, 4 restore low. Returns cycles waited.
    task automatic wait_for(input int which, output int n);
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < BUDGET) begin
            tick();
            n++;
            case (which)
                0:       hit = save_trigger;
                1:       hit = restore_trigger;
                2:       hit = switch_done;
                3:       hit = !save_trigger;
                default: hit = !restore_trigger;
            endcase
        end
        if (!hit) begin
            timeouts++;
            $display("FAIL wait_%0d: event not seen within %0d cycles", which, BUDGET);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; quantum = 16'd5; active_mask = 16'h0003;
        repeat (3) tick();
        total++;
        if ({save_trigger, restore_trigger, cpu_stall, switch_done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000",
                     {save_trigger, restore_trigger, cpu_stall, switch_done});
        end
        total++;
        if ({progIndex, current_prog} !== 8'h00) begin
            bad++;
            $display("FAIL reset_prog: got %h want 00", {progIndex, current_prog});
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_switch();
        int n;
        logic [3:0] exp;
        wait_for(0, n);
        total++;
        if (n !== 5) begin bad++; $display("FAIL basic_expiry: got %0d cycles want 5", n); end
        total++;
        if ({progIndex, restore_trigger, cpu_stall} !== {4'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL basic_save: got idx=%0d rst=%b stall=%b want 0 0 1",
                     progIndex, restore_trigger, cpu_stall);
        end
        exp_q.push_back(4'd1);
        // Mask and yield changes during the switch must not alter the target.
        active_mask = 16'h8001; yield_req = 1'b1;
        tick();
        yield_req = 1'b0;
        total++;
        if ({save_trigger, progIndex} !== {1'b1, 4'd0}) begin
            bad++;
            $display("FAIL basic_save_hold: got save=%b idx=%0d want 1 0", save_trigger, progIndex);
        end
        wait_for(3, n);
        total++;
        if ({save_trigger, restore_trigger, progIndex, cpu_stall} !== {1'b0, 1'b0, 4'd0, 1'b1}) begin
            bad++;
            $display("FAIL basic_gap: got save=%b rst=%b idx=%0d stall=%b want 0 0 0 1",
                     save_trigger, restore_trigger, progIndex, cpu_stall);
        end
        tick();
        total++;
        if ({restore_trigger, save_trigger, progIndex} !== {1'b1, 1'b0, 4'd1}) begin
            bad++;
            $display("FAIL basic_restore: got rst=%b save=%b idx=%0d want 1 0 1",
                     restore_trigger, save_trigger, progIndex);
        end
        wait_for(4, n);
        total++;
        if ({save_trigger, restore_trigger, progIndex, current_prog, cpu_stall, switch_done}
            !== {1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL basic_done: got idx=%0d cur=%0d stall=%b sd=%b want 0 0 1 0",
                     progIndex, current_prog, cpu_stall, switch_done);
        end
        tick();
        if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 4'hx;
        total++;
        if (current_prog !== exp) begin
            bad++; $display("FAIL basic_cur: got %0d want %0d", current_prog, exp);
        end
        total++;
        if ({switch_done, cpu_stall, progIndex} !== {1'b1, 1'b0, exp}) begin
            bad++;
            $display("FAIL basic_run: got sd=%b stall=%b idx=%0d want 1 0 %0d",
                     switch_done, cpu_stall, progIndex, exp);
        end
        tick();
        total++;
        if (switch_done !== 1'b0) begin bad++; $display("FAIL basic_pulse: got %b want 0", switch_done); end
    endtask

    task automatic test_wrap();
        int n;
        logic [3:0] exp;
        logic [3:0] targets [2];
        targets[0] = 4'd15;
        targets[1] = 4'd0;
        for (int i = 0; i < 2; i++) begin
            wait_for(0, n);
            if (i == 1) begin
                total++;
                if (n !== 5) begin bad++; $display("FAIL wrap_slice: got %0d cycles want 5", n); end
            end
            exp_q.push_back(targets[i]);
            wait_for(1, n);
            total++;
            if (progIndex !== targets[i]) begin
                bad++; $display("FAIL wrap_restore_idx: got %0d want %0d", progIndex, targets[i]);
            end
            wait_for(2, n);
            if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 4'hx;
            total++;
            if (current_prog !== exp) begin
                bad++; $display("FAIL wrap_cur: got %0d want %0d", current_prog, exp);
            end
        end
    endtask

    task automatic test_single_runnable();
        int n;
        logic [3:0] exp;
        quantum = 16'd3; active_mask = 16'h0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if ({save_trigger, restore_trigger, cpu_stall} !== 3'b000) begin
                bad++;
                $display("FAIL single_idle: cycle %0d got %b want 000", i,
                         {save_trigger, restore_trigger, cpu_stall});
            end
        end
        // Reloads happened at cycles 5,8,...,20, so a switch now takes 3 cycles.
        active_mask = 16'h0003; quantum = 16'd6;
        wait_for(0, n);
        total++;
        if (n !== 3) begin bad++; $display("FAIL single_reload: got %0d cycles want 3", n); end
        exp_q.push_back(4'd1);
        wait_for(2, n);
        if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 4'hx;
        total++;
        if (current_prog !== exp) begin bad++; $display("FAIL single_cur: got %0d want %0d", current_prog, exp); end
    endtask

    task automatic test_yield();
        int n;
        logic [3:0] exp;
        active_mask = 16'h0005;
        repeat (2) tick();
        total++;
        if (save_trigger !== 1'b0) begin bad++; $display("FAIL yield_early: got %b want 0", save_trigger); end
        yield_req = 1'b1;
        tick();
        yield_req = 1'b0;
        total++;
        if (save_trigger !== 1'b1) begin bad++; $display("FAIL yield_save: got %b want 1", save_trigger); end
        exp_q.push_back(4'd2);
        wait_for(1, n);
        total++;
        if (progIndex !== 4'd2) begin bad++; $display("FAIL yield_next: got %0d want 2", progIndex); end
        wait_for(2, n);
        if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 4'hx;
        total++;
        if (current_prog !== exp) begin bad++; $display("FAIL yield_cur: got %0d want %0d", current_prog, exp); end
    endtask

    task automatic test_enable_hold();
        int n;
        int m;
        logic [3:0] exp;
        active_mask = 16'h0014;
        repeat (2) tick();
        n = 2;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            total++;
            if ({save_trigger, cpu_stall} !== 2'b00) begin
                bad++; $display("FAIL enable_hold: cycle %0d got %b want 00", i, {save_trigger, cpu_stall});
            end
        end
        enable = 1'b1;
        wait_for(0, m);
        n = n + m;
        total++;
        if (n !== 16) begin bad++; $display("FAIL enable_delay: got %0d cycles want 16", n); end
        exp_q.push_back(4'd4);
        wait_for(2, n);
        if (exp_q.size() > 0) exp = exp_q.pop_front(); else exp = 4'hx;
        total++;
        if (current_prog !== exp) begin bad++; $display("FAIL enable_cur: got %0d want %0d", current_prog, exp); end
    endtask

    task automatic test_reset_mid_switch();
        int n;
        wait_for(0, n);
        wait_for(1, n);
        total++;
        if (progIndex !== 4'd2) begin bad++; $display("FAIL midrst_idx: got %0d want 2", progIndex); end
        reset = 1'b1;
        tick();
        total++;
        if ({save_trigger, restore_trigger, cpu_stall, switch_done} !== 4'b0000) begin
            bad++;
            $display("FAIL midrst_flags: got %b want 0000",
                     {save_trigger, restore_trigger, cpu_stall, switch_done});
        end
        total++;
        if ({current_prog, progIndex} !== 8'h00) begin
            bad++; $display("FAIL midrst_prog: got %h want 00", {current_prog, progIndex});
        end
        tick();
        reset = 1'b0;
        wait_for(0, n);
        total++;
        if ({n[7:0], progIndex} !== {8'd6, 4'd0}) begin
            bad++; $display("FAIL midrst_restart: got %0d cycles idx=%0d want 6 0", n, progIndex);
        end
    endtask

    initial begin
        test_reset();
        test_basic_switch();
        test_wrap();
        test_single_runnable();
        test_yield();
        test_enable_hold();
        test_reset_mid_switch();
        total++;
        if (overlap_seen !== 1'b0) begin bad++; $display("FAIL trigger_overlap: got %b want 0", overlap_seen); end
        total++;
        if (timeouts !== 0) begin bad++; $display("FAIL timeouts: got %0d want 0", timeouts); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
